de_serial_arb: RTL and testbench
================================

# de_serial_arb

Round-robin frame arbiter that shares one IN→OUT width converter among NREQ requesters. It grants the converter's input port to one requester for a whole frame of FRAME_BEATS input beats. A frame always contains FRAME_BEATS*IN bits, which is a multiple of OUT, so the converter's output word boundaries stay aligned across source switches. The block sits in front of the converter on a single clock domain and emits frame-boundary strobes and the granted source ID for downstream tagging.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- IN, 12, converter input width in bits
- OUT, 25, converter output width in bits
- FRAME_BEATS, 25, accepted input beats per granted frame; FRAME_BEATS*IN % OUT must be 0, otherwise `$error` at elaboration
- TIMEOUT, 16, stall cycles before padding starts (used only with the macro)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- src_valid  in  NREQ  per-requester beat valid
- src_data  in  NREQ*IN  requester i occupies bits [IN*(i+1)-1 : IN*i]
- src_ready  out  NREQ  per-requester beat accept
- gb_valid  out  1  beat valid toward the converter
- gb_data  out  IN  beat data toward the converter
- gb_ready  in  1  converter can take a beat
- grant  out  NREQ  one-hot current owner; 0 when idle
- grant_id  out  $clog2(NREQ)  index of the current or last owner
- frame_done  out  1  one-cycle pulse after the last beat of a frame
- frame_padded  out  1  high with frame_done when the frame was completed by padding

## Operation
- States: IDLE, XFER, and PAD (PAD is present only when the macro is defined).
- **IDLE:**
  - If any src_valid is high, pick the first requester with valid high, searching circularly from rr_ptr.
  - Register that requester in grant and grant_id and go to XFER.
  - If no src_valid is high, stay in IDLE.
- **XFER (combinational paths):**
  - gb_valid = src_valid[g]
  - gb_data = src_data slice g
  - src_ready[g] = gb_ready
  - All other src_ready are 0.
- **Beat accounting:**
  - A beat is accepted when gb_valid && gb_ready.
  - beat_cnt counts accepted beats and is $clog2(FRAME_BEATS+1) bits wide.
- **End of frame:** on the FRAME_BEATS-th accepted beat:
  - go to IDLE and clear grant and beat_cnt;
  - set rr_ptr = (g+1) mod NREQ;
  - pulse frame_done on the next cycle.
- The grant is never revoked mid-frame when the macro is absent. Dropping src_valid only stalls the frame.
- Outside XFER and PAD, gb_valid = 0 and all src_ready = 0.

## Timing
Reset values:
- state IDLE; grant 0; grant_id 0; rr_ptr 0 (requester 0 has first priority); beat_cnt 0; stall_cnt 0
- frame_done 0; frame_padded 0; gb_valid 0; src_ready 0

Latency:
- src_valid is seen in IDLE at edge t; grant is visible after edge t, and the first beat can be accepted at edge t+1.
- The last beat is accepted at edge t. After edge t: frame_done = 1 for one cycle, state = IDLE, grant = 0.
- The earliest next grant is after edge t+1, so frames are separated by a minimum of one idle cycle.

Boundary conditions:
- A requester raising valid in the same cycle its frame ends is not favoured: rr_ptr has already moved past it.
- With only one requester active, it regains the grant after the one-cycle gap.
- FRAME_BEATS=1: each grant lasts exactly one accepted beat.
- gb_ready low stalls the frame without limit. It does not count toward the timeout.
- rst_n low at any edge returns every register to its reset value next cycle, and a partial frame is abandoned. The converter must share rst_n so its counters realign.

## Configuration
- **DE_SERIAL_ARB_PAD_TIMEOUT_EN defined:**
  - In XFER, stall_cnt increments on every cycle with src_valid[g]=0, and clears on any cycle with src_valid[g]=1.
  - When stall_cnt reaches TIMEOUT, go to PAD.
  - In PAD: gb_valid=1, gb_data=0, all src_ready=0, and beat_cnt keeps counting accepted beats.
  - PAD completes the frame exactly like XFER, and frame_padded pulses together with frame_done.
- **DE_SERIAL_ARB_PAD_TIMEOUT_EN undefined:**
  - The PAD state, stall_cnt and TIMEOUT are unused.
  - frame_padded is tied to 0, and a stalled owner holds the grant indefinitely.

## Test plan
- **Reset then single source:** after reset, req1 holds valid with gb_ready=1. Expect grant=4'b0010 one cycle later, 25 accepted beats, frame_done once, then grant=0 for ≥1 cycle.
- **Round robin:** all four requesters continuously valid. Expect grant order 0,1,2,3,0, each for exactly 25 beats, with exactly one idle cycle between frames.
- **Backpressure:** toggle gb_ready every other cycle during a frame. Expect no src_ready while gb_ready=0, the frame still ends at beat 25, and no padding.
- **Mid-frame reset:** assert rst_n=0 for one cycle after beat 10. Expect all outputs at reset values next cycle and a fresh arbitration starting from requester 0.
- **Timeout (macro on, TIMEOUT=16):** owner drops valid after beat 5. Expect 16 stall cycles, then 20 zero beats on gb_data, with frame_done=1 and frame_padded=1 together.
- **Macro off, same stimulus:** expect the grant held indefinitely, no zero beats, and frame_padded=0 always.

Source files
------------

// File: rtl/de_serial_arb.sv
// de_serial_arb: round-robin frame arbiter sharing one IN->OUT width converter among NREQ requesters
// Ports:
//   clk, rst_n              sole clock; synchronous active-low reset
//   src_valid/src_data      per-requester beats, requester i at src_data[IN*(i+1)-1:IN*i]
//   src_ready               per-requester accept (only the owner can see gb_ready)
//   gb_valid/gb_data        beat toward the converter; gb_ready is its accept
//   grant/grant_id          one-hot current owner (0 when idle) and index of current/last owner
//   frame_done/frame_padded one-cycle pulse after the last beat of a frame; padded flag
// Build option: define DE_SERIAL_ARB_PAD_TIMEOUT_EN to zero-pad a frame whose owner
// withholds valid for TIMEOUT consecutive cycles.
module de_serial_arb #(
  parameter int NREQ        = 4,
  parameter int IN          = 12,
  parameter int OUT         = 25,
  parameter int FRAME_BEATS = 25,
  parameter int TIMEOUT     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         src_valid,
  input  logic [NREQ*IN-1:0]      src_data,
  output logic [NREQ-1:0]         src_ready,
  output logic                    gb_valid,
  output logic [IN-1:0]           gb_data,
  input  logic                    gb_ready,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    frame_done,
  output logic                    frame_padded
);
  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(FRAME_BEATS + 1);
  if ((FRAME_BEATS * IN) % OUT != 0) begin : g_bad_frame
    $error("de_serial_arb: FRAME_BEATS*IN must be a multiple of OUT");
  end
  if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("de_serial_arb: NREQ must be >= 2 and TIMEOUT >= 1");
  end
`ifdef DE_SERIAL_ARB_PAD_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, XFER, PAD} state_t;
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif
  state_t state, state_nxt;
  logic [IDW-1:0] rr_ptr, pick_id, idx;
  logic [BW-1:0] beat_cnt;
  logic [IN-1:0] src_word [NREQ];
  logic accept, last_beat;
  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign src_word[i] = src_data[IN*i +: IN];
  end
  // Lowest circular offset from rr_ptr wins, so scan offsets from high to low.
  always_comb begin
    pick_id = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (src_valid[idx]) pick_id = idx;
    end
  end
  assign accept    = gb_valid && gb_ready;
  assign last_beat = accept && beat_cnt == BW'(FRAME_BEATS - 1);
  always_comb begin
    state_nxt = state;
    gb_valid  = 1'b0;
    gb_data   = '0;
    src_ready = '0;
    if (state == IDLE) state_nxt = |src_valid ? XFER : IDLE;
    if (state == XFER) begin
      gb_valid            = src_valid[grant_id];
      gb_data             = src_word[grant_id];
      src_ready[grant_id] = gb_ready;
    end
`ifdef DE_SERIAL_ARB_PAD_TIMEOUT_EN
    if (state == PAD) gb_valid = 1'b1;
    if (state == XFER && !src_valid[grant_id] && stall_cnt == SW'(TIMEOUT - 1)) state_nxt = PAD;
`endif
    if (last_beat) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= last_beat;
      if (state == IDLE && |src_valid) begin
        grant    <= NREQ'(1) << pick_id;
        grant_id <= pick_id;
      end
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (last_beat) begin
        grant  <= '0;
        rr_ptr <= grant_id == IDW'(NREQ - 1) ? '0 : grant_id + 1'b1;
      end
    end
  end
`ifdef DE_SERIAL_ARB_PAD_TIMEOUT_EN
  // Only owner silence counts; converter backpressure never advances the timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      frame_padded <= 1'b0;
    end else begin
      stall_cnt    <= state == XFER && !src_valid[grant_id] ? stall_cnt + 1'b1 : '0;
      frame_padded <= last_beat && state == PAD;
    end
  end
`else
  assign frame_padded = 1'b0;
`endif
endmodule

// File: tb/tb_de_serial_arb.sv
// tb_de_serial_arb: randomized self-checking bench for de_serial_arb against a transaction-level model
module tb_de_serial_arb;
  localparam int NREQ = 4;
  localparam int IN   = 12;
  localparam int OUT  = 25;
  localparam int FB   = 25;
  localparam int TO   = 16;
  localparam int IDW  = $clog2(NREQ);
  localparam int VW   = 2*NREQ + IDW + IN + 3;
`ifdef DE_SERIAL_ARB_PAD_TIMEOUT_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] src_valid;
  logic [NREQ*IN-1:0] src_data;
  logic [NREQ-1:0] src_ready;
  logic gb_valid;
  logic [IN-1:0] gb_data;
  logic gb_ready;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_id;
  logic frame_done, frame_padded;
  logic [IN-1:0] words [NREQ];
  logic [VW-1:0] dut_vec;
  int passes = 0;
  int total = 0;
  int m_owner, m_last, m_cnt, m_ptr, m_stall;
  bit m_done, m_padded, m_pad;

  de_serial_arb #(.NREQ(NREQ), .IN(IN), .OUT(OUT), .FRAME_BEATS(FB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .gb_valid(gb_valid), .gb_data(gb_data), .gb_ready(gb_ready), .grant(grant),
    .grant_id(grant_id), .frame_done(frame_done), .frame_padded(frame_padded));

  always #5 clk = ~clk;
  for (genvar i = 0; i < NREQ; i++) begin : g_d
    assign src_data[IN*i +: IN] = words[i];
  end
  assign dut_vec = {grant, grant_id, gb_valid, gb_data, src_ready, frame_done, frame_padded};

  // Expected outputs for the current cycle from the model's owner/pad view and live inputs.
  function automatic logic [VW-1:0] model_exp();
    logic [NREQ-1:0] g, rdy;
    logic v;
    logic [IN-1:0] d;
    g = '0; rdy = '0; v = 1'b0; d = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      v = m_pad ? 1'b1 : src_valid[m_owner];
      d = m_pad ? '0 : words[m_owner];
      if (!m_pad) rdy[m_owner] = gb_ready;
    end
    return {g, IDW'(m_last), v, d, rdy, m_done, m_padded};
  endfunction

  // Advance the model across one clock edge using the inputs currently applied.
  function automatic void model_step();
    bit acc, found;
    acc = m_owner >= 0 && gb_ready && (m_pad || src_valid[m_owner]);
    if (!rst_n) begin
      m_owner = -1; m_last = 0; m_cnt = 0; m_ptr = 0; m_stall = 0;
      m_done = 0; m_padded = 0; m_pad = 0;
      return;
    end
    m_done = 0;
    m_padded = 0;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++)
        if (!found && src_valid[(m_ptr + k) % NREQ]) begin
          found = 1;
          m_owner = (m_ptr + k) % NREQ;
          m_last = m_owner;
        end
    end else begin
      if (acc) m_cnt++;
      if (m_cnt == FB) begin
        m_done = 1; m_padded = m_pad; m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1; m_cnt = 0; m_pad = 0; m_stall = 0;
      end else if (PAD_EN && !m_pad) begin
        if (src_valid[m_owner]) m_stall = 0;
        else begin
          m_stall++;
          if (m_stall == TO) m_pad = 1;
        end
      end
    end
  endfunction

  task automatic settle(input logic [NREQ-1:0] v, input logic r);
    src_valid = v;
    gb_ready = r;
    for (int i = 0; i < NREQ; i++) words[i] = IN'($urandom);
    @(negedge clk);
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    settle('0, 1'b0);
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle(NREQ'($urandom), 1'b1);
      if ({grant, grant_id, gb_valid, src_ready, frame_done, frame_padded} !== '0)
        $display("FAIL reset_outputs got=%h exp=0", {grant, grant_id, gb_valid, src_ready, frame_done, frame_padded});
      else passes++;
      total++;
      if (dut_vec !== model_exp()) $display("FAIL reset_model got=%h exp=%h", dut_vec, model_exp());
      else passes++;
      total++;
      adv();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_source();
    int beats = 0;
    bit done = 0;
    do_reset();
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      settle(NREQ'(2), 1'b1);
      if (dut_vec !== model_exp()) $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_exp());
      else passes++;
      total++;
      if (cyc == 1) begin
        if (grant !== NREQ'(2)) $display("FAIL single_first_grant got=%b exp=0010", grant);
        else passes++;
        total++;
      end
      if (gb_valid && gb_ready) beats++;
      if (frame_done) begin
        done = 1;
        if (grant !== '0) $display("FAIL single_gap_grant got=%b exp=0000", grant);
        else passes++;
        total++;
      end
      adv();
    end
    if (!done || beats != FB) $display("FAIL single_beats got=%0d done=%0d exp=%0d", beats, done, FB);
    else passes++;
    total++;
    settle(NREQ'(2), 1'b1);
    if (grant !== NREQ'(2)) $display("FAIL single_regain got=%b exp=0010", grant);
    else passes++;
    total++;
    adv();
  endtask

  task automatic test_round_robin();
    int owners[$];
    int gaps[$];
    int fbeats[$];
    int beats = 0, idle = 0, dones = 0;
    logic [NREQ-1:0] prev = '0;
    do_reset();
    for (int cyc = 0; cyc < 400 && dones < 5; cyc++) begin
      settle('1, 1'b1);
      if (dut_vec !== model_exp()) $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_exp());
      else passes++;
      total++;
      if (grant != '0 && prev == '0) begin
        owners.push_back(int'(grant_id));
        if (owners.size() > 1) gaps.push_back(idle);
      end
      idle = grant == '0 ? idle + 1 : 0;
      if (gb_valid && gb_ready) beats++;
      if (frame_done) begin
        fbeats.push_back(beats);
        beats = 0;
        dones++;
      end
      prev = grant;
      adv();
    end
    if (owners.size() != 5) $display("FAIL rr_frames got=%0d exp=5", owners.size());
    else passes++;
    total++;
    foreach (owners[i]) begin
      if (owners[i] != i % NREQ) $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, owners[i], i % NREQ);
      else passes++;
      total++;
    end
    foreach (gaps[i]) begin
      if (gaps[i] != 1) $display("FAIL rr_gap idx=%0d got=%0d exp=1", i, gaps[i]);
      else passes++;
      total++;
    end
    foreach (fbeats[i]) begin
      if (fbeats[i] != FB) $display("FAIL rr_len idx=%0d got=%0d exp=%0d", i, fbeats[i], FB);
      else passes++;
      total++;
    end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    bit done = 0;
    do_reset();
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      settle(NREQ'($urandom) | NREQ'(1), cyc % 2 == 1);
      if (dut_vec !== model_exp()) $display("FAIL bp_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_exp());
      else passes++;
      total++;
      if (!gb_ready) begin
        if (src_ready !== '0) $display("FAIL bp_ready cyc=%0d got=%b exp=0000", cyc, src_ready);
        else passes++;
        total++;
      end
      if (gb_valid && gb_ready) beats++;
      if (frame_done) begin
        done = 1;
        if (frame_padded !== 1'b0) $display("FAIL bp_padded got=%b exp=0", frame_padded);
        else passes++;
        total++;
      end
      adv();
    end
    if (!done || beats != FB) $display("FAIL bp_beats got=%0d done=%0d exp=%0d", beats, done, FB);
    else passes++;
    total++;
  endtask

  task automatic test_mid_reset();
    int beats = 0;
    bit first = 0;
    do_reset();
    for (int cyc = 0; cyc < 300 && beats < 10; cyc++) begin
      settle('1, 1'b1);
      if (dut_vec !== model_exp()) $display("FAIL mr_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_exp());
      else passes++;
      total++;
      if (first && gb_valid && gb_ready) beats++;
      if (frame_done) first = 1;
      adv();
    end
    if (grant !== NREQ'(2)) $display("FAIL mr_owner got=%b exp=0010", grant);
    else passes++;
    total++;
    rst_n = 1'b0;
    settle('1, 1'b1);
    adv();
    rst_n = 1'b1;
    settle('1, 1'b1);
    if ({grant, grant_id, gb_valid, src_ready, frame_done, frame_padded} !== '0)
      $display("FAIL mr_cleared got=%h exp=0", {grant, grant_id, gb_valid, src_ready, frame_done, frame_padded});
    else passes++;
    total++;
    if (dut_vec !== model_exp()) $display("FAIL mr_model_after got=%h exp=%h", dut_vec, model_exp());
    else passes++;
    total++;
    adv();
    settle('1, 1'b1);
    if (grant !== NREQ'(1)) $display("FAIL mr_restart got=%b exp=0001", grant);
    else passes++;
    total++;
    adv();
  endtask

  task automatic test_timeout();
    int beats = 0, stall = 0, zero = 0, dones = 0, pads = 0;
    do_reset();
    for (int cyc = 0; cyc < 150 && dones == 0; cyc++) begin
      settle(beats >= 5 ? '0 : NREQ'(1), 1'b1);
      if (dut_vec !== model_exp()) $display("FAIL to_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_exp());
      else passes++;
      total++;
      if (beats >= 5) begin
        if (grant != '0 && !gb_valid) stall++;
        if (gb_valid && gb_ready && gb_data == '0 && src_ready == '0) zero++;
      end else if (gb_valid && gb_ready) beats++;
      if (frame_done) dones++;
      if (frame_padded) pads++;
      if (frame_done) begin
        if (frame_padded !== PAD_EN) $display("FAIL to_pad_flag got=%b exp=%b", frame_padded, PAD_EN);
        else passes++;
        total++;
      end
      adv();
    end
`ifdef DE_SERIAL_ARB_PAD_TIMEOUT_EN
    if (stall != TO) $display("FAIL to_stall got=%0d exp=%0d", stall, TO);
    else passes++;
    total++;
    if (zero != FB - 5) $display("FAIL to_zero_beats got=%0d exp=%0d", zero, FB - 5);
    else passes++;
    total++;
    if (dones != 1 || pads != 1) $display("FAIL to_done got=%0d/%0d exp=1/1", dones, pads);
    else passes++;
    total++;
`else
    if (grant !== NREQ'(1)) $display("FAIL to_hold got=%b exp=0001", grant);
    else passes++;
    total++;
    if (zero != 0 || dones != 0 || pads != 0) $display("FAIL to_nopad got=%0d/%0d/%0d exp=0/0/0", zero, dones, pads);
    else passes++;
    total++;
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst_n = $urandom_range(0, 199) != 0;
      settle(NREQ'($urandom) & NREQ'($urandom | $urandom), $urandom_range(0, 3) != 0);
      if (dut_vec !== model_exp()) $display("FAIL rand_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_exp());
      else passes++;
      total++;
      adv();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    src_valid = '0;
    gb_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) words[i] = '0;
    adv();
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
